layer_mac_sequencer: RTL and testbench

- Sequences one fully-connected layer: for each of three neuron rows, accumulates NUM_COLS weight×activation products, applies fixed-point scaling, ReLU and saturation, then emits one neuron output.
- Drives the row_index_counter (clear/increment) and consumes its row_index/last_value.
- Produces col_index to address weight and activation memories.
- Sits between the layer controller (start/done) and the next layer's input buffer (valid/ready).

---
 rtl/layer_mac_sequencer.sv | 137 +++++++++++++
 tb/tb_layer_mac_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mac_sequencer.sv
// Fully-connected layer sequencer: per row, accumulates NUM_COLS weight x activation
// products, scales, applies ReLU/saturation and hands the neuron result downstream.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | clear external row counter, accumulator and column index
// MAC   | one product accumulated per cycle, NUM_COLS cycles per row
// EMIT  | neuron output valid, waiting for out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module layer_mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_COLS   = 3,
    parameter int COL_WIDTH  = 2,
    parameter int ACC_WIDTH  = 18,
    parameter int FRAC_BITS  = 4
) (
    input  logic                         clock,
    input  logic                         clear_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic [1:0]                   row_index,
    input  logic                         last_row,
    output logic                         row_clear,
    output logic                         row_increment,
    output logic [COL_WIDTH-1:0]         col_index,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0] activation,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [1:0]                   out_row
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [COL_WIDTH-1:0]        LAST_COL = COL_WIDTH'(NUM_COLS - 1);
    localparam logic signed [ACC_WIDTH-1:0] MAX_OUT  = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);

    state_t                         state;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]    sum_next;
    logic signed [ACC_WIDTH-1:0]    scaled;
    logic [DATA_WIDTH-1:0]          sat_data;
    logic                           handshake;

    assign product  = weight * activation;
    assign sum_next = acc + $signed({{(ACC_WIDTH - 2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product});
    assign scaled   = sum_next >>> FRAC_BITS;

    // ReLU then clamp to the positive range of the output width
    always_comb begin
        sat_data = '0;
        if (scaled[ACC_WIDTH-1]) begin
            sat_data = '0;
        end else if (scaled > MAX_OUT) begin
            sat_data = MAX_OUT[DATA_WIDTH-1:0];
        end else begin
            sat_data = scaled[DATA_WIDTH-1:0];
        end
    end

    // The increment must land in the accepting cycle, so it follows out_ready directly
    assign handshake     = (state == S_EMIT) && out_ready;
    assign row_increment = handshake && !last_row;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            col_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            row_clear <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
        end else begin
            done      <= 1'b0;
            row_clear <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLR;
                        busy      <= 1'b1;
                        row_clear <= 1'b1;
                    end
                end
                S_CLR: begin
                    acc       <= '0;
                    col_index <= '0;
                    state     <= S_MAC;
                end
                S_MAC: begin
                    acc <= sum_next;
                    if (col_index == LAST_COL) begin
                        col_index <= '0;
                        out_data  <= sat_data;
                        out_row   <= row_index;
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        col_index <= col_index + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        if (last_row) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_MAC;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: models the row counter and weight/activation
// memories, and checks outputs against a plain-arithmetic neuron model.
module tb_layer_mac_sequencer;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          clear_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [1:0]    row_index;
    logic          last_row;
    logic          row_clear;
    logic          row_increment;
    logic [1:0]    col_index;
    logic signed [DW-1:0] weight;
    logic signed [DW-1:0] activation;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_row;

    int n_checks = 0;
    int n_fail   = 0;

    int w_mem [3][3];
    int x_mem [3];
    int exp_data [3];
    int row_cnt = 1;

    layer_mac_sequencer dut (
        .clock         (clock),
        .clear_n       (clear_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .row_index     (row_index),
        .last_row      (last_row),
        .row_clear     (row_clear),
        .row_increment (row_increment),
        .col_index     (col_index),
        .weight        (weight),
        .activation    (activation),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row       (out_row)
    );

    always #5 clock = ~clock;

    // External row counter; deliberately not tied to clear_n so row_clear must do the work
    always @(posedge clock) begin
        if (row_clear)          row_cnt <= 0;
        else if (row_increment) row_cnt <= row_cnt + 1;
    end

    assign row_index = 2'(row_cnt);
    assign last_row  = (row_cnt == 2);

    always_comb begin
        weight     = '0;
        activation = '0;
        if (row_cnt >= 0 && row_cnt < 3 && col_index < 2'd3) begin
            weight     = DW'(w_mem[row_cnt][col_index]);
            activation = DW'(x_mem[col_index]);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compute_expected();
        for (int r = 0; r < 3; r++) begin
            int sum = 0;
            int s;
            for (int c = 0; c < 3; c++) sum += w_mem[r][c] * x_mem[c];
            s = sum >>> 4;
            if (s < 0)        exp_data[r] = 0;
            else if (s > 127) exp_data[r] = 127;
            else              exp_data[r] = s;
        end
    endtask

    task automatic fill(input int w, input int x);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w_mem[r][c] = w;
        for (int c = 0; c < 3; c++) x_mem[c] = x;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w_mem[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < 3; c++) x_mem[c] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Entered just after a negedge in an IDLE cycle; that cycle is cycle 0 (start asserted).
    // ready_mode: 0 always ready, 1 random, 2 five stall cycles on row 0.
    task automatic run_layer(input int ready_mode, input bit inject, input bit check_lat);
        int  cyc = 0;
        int  k = 0;
        int  rc_cnt = 0;
        int  done_cyc = -1;
        int  stall_left = 5;
        bit  held = 1'b0;
        bit  hs;
        bit  r;
        int  held_data = 0;
        int  held_row = 0;
        compute_expected();
        start     = 1'b1;
        out_ready = 1'b0;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            start = (inject && cyc == 3);
            if (ready_mode == 0) r = 1'b1;
            else if (ready_mode == 1) r = 1'($urandom_range(0, 1));
            else if (out_valid && k == 0 && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else r = 1'b1;
            out_ready = r;
            #1;
            hs = out_valid && out_ready;
            if (row_clear) rc_cnt++;
            check("busy_high", int'(busy), 1);
            check("row_increment", int'(row_increment), int'(hs && k < 2));
            if (held) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), held_data);
                check("stall_row", int'(out_row), held_row);
            end
            if (hs) begin
                if (k < 3) begin
                    check("out_data", int'(out_data), exp_data[k]);
                    check("out_row", int'(out_row), k);
                end
                k++;
            end
            held      = out_valid && !out_ready;
            held_data = int'(out_data);
            held_row  = int'(out_row);
            if (done) done_cyc = cyc;
        end
        check("done_seen", int'(done_cyc >= 0), 1);
        check("outputs_accepted", k, 3);
        check("row_clear_once", rc_cnt, 1);
        if (check_lat) check("done_latency", done_cyc, 14);
        if (ready_mode == 2) check("stall_used", stall_left, 0);
        start = inject;
        @(negedge clock);
        start     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("idle_busy", int'(busy), 0);
        check("done_pulse", int'(done), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_rclr"}, int'(row_clear), 0);
        check({tag, "_rinc"}, int'(row_increment), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_data"}, int'(out_data), 0);
        check({tag, "_row"}, int'(out_row), 0);
        check({tag, "_col"}, int'(col_index), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        fill(1, 16);
        repeat (3) @(negedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);

        // basic layer: each row 3*16 = 48, >>>4 = 3
        fill(1, 16);
        run_layer(0, 1'b0, 1'b1);

        // ReLU on row 1
        fill(1, 16);
        for (int c = 0; c < 3; c++) w_mem[1][c] = -1;
        run_layer(0, 1'b0, 1'b1);

        // saturation high and the most negative sum
        fill(127, 127);
        run_layer(0, 1'b0, 1'b1);
        fill(-128, 127);
        run_layer(0, 1'b0, 1'b1);

        // backpressure on row 0
        fill_random();
        run_layer(2, 1'b0, 1'b0);

        // start mid-MAC and in DONE ignored; immediate second layer identical
        fill_random();
        run_layer(0, 1'b1, 1'b1);
        run_layer(0, 1'b0, 1'b1);

        // reset during row 1 MAC
        fill(5, 40);
        start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            start     = 1'b0;
            out_ready = 1'b1;
        end
        #1;
        clear_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        clear_n   = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        run_layer(0, 1'b0, 1'b1);

        // randomized layers with random backpressure
        for (int n = 0; n < 12; n++) begin
            fill_random();
            run_layer(1, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
